// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V instruction-fetch stage: PC, instruction bus master, IF/DE register
//
// Owns the program counter and keeps at most one instruction-bus read
// outstanding. It presents each fetched word to decode. A response that
// arrives while decode is stalled is parked in a one-entry hold buffer.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   jump_flag_i     redirect from the pipeline controller (highest priority)
//   jump_addr_i     redirect target, valid with jump_flag_i
//   stall_i[0]      hold PC / block issuing a new request
//   stall_i[1]      hold the IF/DE output register
//   ibus_req_o      read request (registered state only)
//   ibus_addr_o     request address (= pc)
//   ibus_gnt_i      request accepted this cycle
//   ibus_rvalid_i   read data valid
//   ibus_rdata_i    read data
//   inst_o          instruction to decode (NOP_INST on bubbles)
//   inst_addr_o     PC of inst_o
//   inst_valid_o    inst_o is a real fetched instruction

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [1:0]  stall_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  state_t      resume_st;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic        buf_full_q, buf_full_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        inst_valid_q, inst_valid_d;

  // Bus outputs come straight from registers so they never depend on gnt.
  assign ibus_req_o   = (state_q == S_REQ);
  assign ibus_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

  // Where to go once a transaction finishes: issue again unless PC is held.
  assign resume_st = stall_i[0] ? S_IDLE : S_REQ;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    kill_d       = kill_q;
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;
    buf_full_d   = buf_full_q;
    // Without a load, the output register either holds or turns into a bubble.
    // A bubble keeps the last address.
    inst_d       = stall_i[1] ? inst_q : NOP_INST;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = stall_i[1] ? inst_valid_q : 1'b0;

    if (jump_flag_i) begin
      pc_d         = jump_addr_i;
      inst_d       = NOP_INST;
      inst_addr_d  = jump_addr_i;
      inst_valid_d = 1'b0;
      buf_full_d   = 1'b0;
      case (state_q)
        S_REQ: begin
          // A grant in the redirect cycle fetches a stale address. Wait out its
          // response and drop it. The pc stays at the target.
          if (ibus_gnt_i) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = resume_st;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = resume_st;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = resume_st;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stall_i[0]) state_d = S_REQ;
        end
        S_REQ: begin
          // Once in REQ the request stays up until granted, even if stall_i[0] rises.
          if (ibus_gnt_i) begin
            fetch_addr_d = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = resume_st;
            end else if (!stall_i[1]) begin
              inst_d       = ibus_rdata_i;
              inst_addr_d  = fetch_addr_q;
              inst_valid_d = 1'b1;
              state_d      = resume_st;
            end else begin
              buf_data_d = ibus_rdata_i;
              buf_addr_d = fetch_addr_q;
              buf_full_d = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i[1] && buf_full_q) begin
            inst_d       = buf_data_q;
            inst_addr_d  = buf_addr_q;
            inst_valid_d = 1'b1;
            buf_full_d   = 1'b0;
            state_d      = resume_st;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      kill_q       <= 1'b0;
      buf_data_q   <= 32'h0;
      buf_addr_q   <= 32'h0;
      buf_full_q   <= 1'b0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      kill_q       <= kill_d;
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
      buf_full_q   <= buf_full_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V core: owns the program counter, issues instruction reads on the instruction bus, and presents fetched instructions to the decode stage. It sits directly downstream of the pipeline controller. It consumes the controller's jump flag and jump address, plus the low two bits of its stall vector. At most one bus transaction is outstanding at a time. A one-entry hold buffer absorbs a response that returns while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- NOP_INST, 32'h0000_0013, instruction word presented on bubbles (addi x0,x0,0)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- jump_flag_i  in  1  redirect request from controller; highest priority
- jump_addr_i  in  32  redirect target; valid when jump_flag_i=1
- stall_i  in  2  bit0: hold PC / block new request issue; bit1: hold IF/DE output register
- ibus_req_o  out  1  bus read request
- ibus_addr_o  out  32  request address (= pc)
- ibus_gnt_i  in  1  request accepted this cycle when ibus_req_o=1
- ibus_rvalid_i  in  1  read data valid; earliest one cycle after gnt
- ibus_rdata_i  in  32  read data
- inst_o  out  32  instruction to decode
- inst_addr_o  out  32  PC of inst_o
- inst_valid_o  out  1  inst_o holds a real fetched instruction

## Operation
- Registers:
  - pc;
  - fetch_addr (address of the outstanding request);
  - kill flag;
  - hold buffer (data, addr, full);
  - output register (inst_o, inst_addr_o, inst_valid_o).
- FSM states: IDLE, REQ, WAIT, HOLD. "NEXT" below means REQ if stall_i[0]=0, else IDLE.
- IDLE: ibus_req_o=0. Go to REQ when stall_i[0]=0.
- REQ: ibus_req_o=1, ibus_addr_o=pc. On gnt: fetch_addr<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), go to WAIT.
- WAIT: ibus_req_o=0. On rvalid:
  - kill=1: discard data, clear kill, go NEXT.
  - stall_i[1]=0: output <= {rdata, fetch_addr, valid=1}, go NEXT.
  - stall_i[1]=1: buffer <= {rdata, fetch_addr}, full=1, go HOLD.
- HOLD: wait for stall_i[1]=0. Then move buffer to output (valid=1), clear full, go NEXT.
- Output register rules, applied in every cycle without a load:
  - stall_i[1]=1: output holds.
  - stall_i[1]=0: output <= {NOP_INST, inst_addr_o unchanged, valid=0} (bubble).
- jump_flag_i=1 overrides everything in that cycle:
  - pc<=jump_addr_i.
  - Output <= {NOP_INST, jump_addr_i, 0}, regardless of stall_i.
  - Hold buffer cleared.
- Per-state behaviour on jump:
  - REQ with no gnt: go NEXT; request re-issues with the new pc.
  - REQ with gnt the same cycle: the granted request is stale. Go to WAIT with kill=1; pc stays jump_addr_i (no +4).
  - WAIT with no rvalid: kill<=1, stay in WAIT.
  - WAIT with rvalid the same cycle: drop data, kill<=0, go NEXT.
  - HOLD or IDLE: go NEXT.
- jump_addr_i[1:0] is passed through unchecked; misalignment is handled elsewhere.

## Timing
- Reset values (synchronous, on rst_n=0 at a clock edge):
  - pc=RESET_PC;
  - state=IDLE;
  - ibus_req_o=0;
  - ibus_addr_o=RESET_PC;
  - kill=0;
  - buffer full=0;
  - inst_o=NOP_INST;
  - inst_addr_o=0;
  - inst_valid_o=0.
- First request: ibus_req_o=1 in the first cycle after rst_n deasserts (IDLE->REQ), if stall_i[0]=0.
- Latency: gnt in cycle N, rvalid in N+1 puts the instruction on inst_o in cycle N+2.
- Peak throughput: one instruction per 2 cycles (REQ, WAIT).
- ibus_req_o and ibus_addr_o are driven from registered state and pc only. They do not combinationally depend on gnt.
- Reset mid-transaction: the block returns to IDLE and forgets the outstanding request. A late rvalid arriving in IDLE or REQ is ignored. The bus must tolerate this; same-cycle reset of the bus is the system contract.
- stall_i[0]=1 never cancels a request already in REQ. It only blocks starting a new one.

## Test plan
- Reset then free-run, gnt same cycle, rvalid +1, rdata=addr^32'hA5A5_0000 -> requests at 0x0,0x4,0x8. inst_o/inst_addr_o pairs appear 2 cycles after each gnt with valid=1, a bubble (NOP, valid=0) between them.
- rvalid while stall_i=2'b10 for 3 cycles -> state HOLD, output unchanged, no new req. On release, inst_o=buffered data on the next edge, then req resumes at the next pc.
- jump_flag_i=1, jump_addr_i=0x100 during WAIT (fetch of 0x8 outstanding) -> the 0x8 response is dropped and inst_valid_o stays 0. Next request addr=0x100; first valid inst_addr_o=0x100.
- jump_flag_i in the same cycle as gnt of 0xC -> WAIT with kill. The 0xC data is discarded, then a request for the target is issued; pc is never target+4 before the target is fetched.
- pc=0xFFFF_FFFC fetch -> next ibus_addr_o=0x0000_0000.
- rst_n=0 during WAIT, with rvalid arriving one cycle after reset release -> outputs at reset values, the data is ignored, and the first request goes to RESET_PC.
